// File: rtl/llc_input_arbiter.sv
// LLC input arbiter: grants one of rsp/req/dma into the transaction pipeline.
// Fixed priority rsp > req > dma, with a starvation guard that forces a DMA grant.
module llc_input_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_valid,
  input  logic             req_valid,
  input  logic             dma_valid,
  input  logic             req_stall,
  input  logic             arb_en,
  input  logic             txn_done,
  output logic             rsp_pop,
  output logic             req_pop,
  output logic             dma_pop,
  output logic [2:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] starve_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t     state;
  logic       e_rsp, e_req, e_dma, force_dma, any_elig;
  logic       cnt_sat;
  logic [2:0] winner;

  always_comb begin
    e_rsp     = rsp_valid;
    e_req     = req_valid & ~req_stall;
    e_dma     = dma_valid & ~req_stall;
    cnt_sat   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    force_dma = e_dma & cnt_sat;
    any_elig  = e_rsp | e_req | e_dma;
    winner    = '0;
    if (force_dma)  winner = 3'b100;
    else if (e_rsp) winner = 3'b001;
    else if (e_req) winner = 3'b010;
    else if (e_dma) winner = 3'b100;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      rsp_pop    <= 1'b0;
      req_pop    <= 1'b0;
      dma_pop    <= 1'b0;
      busy       <= 1'b0;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (txn_done) proto_err <= 1'b1;
          // An absent DMA request clears its history even without arbitration.
          if (!dma_valid) starve_cnt <= '0;
          if (arb_en && any_elig) begin
            state                       <= GRANT;
            grant                       <= winner;
            {dma_pop, req_pop, rsp_pop} <= winner;
            busy                        <= 1'b1;
            if (winner[2])             starve_cnt <= '0;
            else if (e_dma && !cnt_sat) starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        GRANT: begin
          if (txn_done) proto_err <= 1'b1;
          {dma_pop, req_pop, rsp_pop} <= '0;
          state                       <= BUSY;
        end
        BUSY: begin
          if (txn_done) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Scoreboard bench for llc_input_arbiter: transaction-level reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_llc_input_arbiter;
  localparam int unsigned LIM = 4;
  localparam int unsigned CW  = $clog2(LIM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rsp_valid, req_valid, dma_valid, req_stall, arb_en, txn_done;
  logic          rsp_pop, req_pop, dma_pop, busy, proto_err;
  logic [2:0]    grant;
  logic [CW-1:0] starve_cnt;

  llc_input_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .req_valid(req_valid), .dma_valid(dma_valid),
    .req_stall(req_stall), .arb_en(arb_en), .txn_done(txn_done),
    .rsp_pop(rsp_pop), .req_pop(req_pop), .dma_pop(dma_pop),
    .grant(grant), .busy(busy), .starve_cnt(starve_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    grant;
    logic [2:0]    pop;
    logic          busy;
    logic [CW-1:0] starve;
    logic          proto;
  } obs_t;

  typedef struct packed {
    logic [2:0]    ch;
    logic [CW-1:0] starve;
  } txn_t;

  obs_t cyc_q[$];
  txn_t txn_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: age 0 = idle, 1 = first cycle of a grant, 2+ = waiting for done.
  int unsigned m_age    = 0;
  logic [2:0]  m_owner  = '0;
  int unsigned m_starve = 0;
  bit          m_proto  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rv, input bit qv, input bit dv,
                            input bit st, input bit ae, input bit td);
    obs_t o;
    txn_t t;
    bit er, eq, ed;
    if (m_age == 0) begin
      if (td) m_proto = 1'b1;
      if (!dv) m_starve = 0;
      er = rv;
      eq = qv && !st;
      ed = dv && !st;
      if (ae && (er || eq || ed)) begin
        if (ed && m_starve == LIM) m_owner = 3'b100;
        else if (er)               m_owner = 3'b001;
        else if (eq)               m_owner = 3'b010;
        else                       m_owner = 3'b100;
        if (m_owner == 3'b100) m_starve = 0;
        else if (ed)           m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        t.ch     = m_owner;
        t.starve = CW'(m_starve);
        txn_q.push_back(t);
        m_age = 1;
      end
    end else if (m_age == 1) begin
      if (td) m_proto = 1'b1;
      m_age = 2;
    end else if (td) begin
      m_age = 0;
    end
    o.grant  = (m_age != 0) ? m_owner : 3'b000;
    o.pop    = (m_age == 1) ? m_owner : 3'b000;
    o.busy   = (m_age != 0);
    o.starve = CW'(m_starve);
    o.proto  = m_proto;
    cyc_q.push_back(o);
  endtask

  task automatic step(input bit rv, input bit qv, input bit dv,
                      input bit st, input bit ae, input bit td);
    @(negedge clk);
    rst       = 1'b1;
    rsp_valid = rv;
    req_valid = qv;
    dma_valid = dv;
    req_stall = st;
    arb_en    = ae;
    txn_done  = td;
    model_step(rv, qv, dv, st, ae, td);
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {20'd0, grant, rsp_pop, req_pop, dma_pop, busy, proto_err},
        32'd0);
    chk("async_reset_starve", {{(32-CW){1'b0}}, starve_cnt}, 32'd0);
    chk("pending_pops_at_reset", txn_q.size(), 0);
    txn_q.delete();
    m_age = 0; m_owner = '0; m_starve = 0; m_proto = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      cyc_q.push_back('0);
    end
  endtask

  // Monitor: compares every cycle, and pops the transaction queue on each pop strobe.
  always begin
    obs_t e;
    txn_t t;
    logic [2:0] pops;
    @(posedge clk);
    #2;
    pops = {dma_pop, req_pop, rsp_pop};
    if (cyc_q.size() != 0) begin
      e = cyc_q.pop_front();
      chk("cycle_state", {18'd0, grant, pops, busy, proto_err, 3'd0, starve_cnt},
          {18'd0, e.grant, e.pop, e.busy, e.proto, 3'd0, e.starve});
    end
    if (pops != 3'b000) begin
      if (txn_q.size() == 0) begin
        chk("unexpected_pop", {29'd0, pops}, 32'd0);
      end else begin
        t = txn_q.pop_front();
        chk("pop_channel", {29'd0, pops}, {29'd0, t.ch});
        chk("grant_channel", {29'd0, grant}, {29'd0, t.ch});
        chk("grant_starve", {{(32-CW){1'b0}}, starve_cnt}, {{(32-CW){1'b0}}, t.starve});
      end
    end
  end

  initial begin
    rst = 1'b0;
    rsp_valid = 1'b0; req_valid = 1'b0; dma_valid = 1'b0;
    req_stall = 1'b0; arb_en = 1'b0; txn_done = 1'b0;
    do_reset(2);

    // All valid: rsp wins, done two cycles after grant.
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    // Stall blocks req and dma; releasing it grants req and bumps the DMA count.
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 1, 1);

    // Held req + dma until the starvation guard forces DMA through.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 0, 1, 0);
      step(0, 1, 1, 0, 1, 0);
      step(0, 1, 1, 0, 1, 1);
    end

    // Stray done while idle sets the sticky error.
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // DMA grant, then reset while busy.
    step(0, 0, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    do_reset(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

    // arb_en low holds off a waiting rsp.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rv, qv, dv, st, ae, td;
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        rv = ($urandom_range(0, 99) < 40);
        qv = ($urandom_range(0, 99) < 60);
        dv = ($urandom_range(0, 99) < 70);
        st = ($urandom_range(0, 99) < 20);
        ae = ($urandom_range(0, 99) < 80);
        td = (m_age >= 2) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 199) == 0);
        step(rv, qv, dv, st, ae, td);
      end
    end

    // Drain: finish any open transaction and let the monitor catch up.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, (m_age >= 2));
    @(posedge clk);
    #3;
    chk("txn_queue_drained", txn_q.size(), 0);
    chk("cycle_queue_drained", cyc_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
